// File: rtl/xout_window_accum.sv
// xout_window_accum
//   Window accumulator placed after the 8-bit result stage. It takes one
//   unsigned sample per XIN handshake and sums WINDOW samples. It also tracks
//   the largest sample in the window. At the end of each window it presents
//   the sum and the maximum on a valid/ready output port.
//
//   Optional feature macro: XWIN_SAT_EN
//     defined   : the accumulator saturates at 2^ACC_BITS-1, and the port
//                 SUM_OVF carries a sticky per-window overflow flag.
//     undefined : the accumulator wraps modulo 2^ACC_BITS, and SUM_OVF is absent.
//
//   Requires ACC_BITS >= NBITS and 2 <= WINDOW <= 256.

module xout_window_accum #(
    parameter int unsigned NBITS    = 8,
    parameter int unsigned WINDOW   = 4,
    parameter int unsigned ACC_BITS = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                XIN_VALID,
    input  logic [NBITS-1:0]    XIN,
    output logic                XIN_READY,
    output logic                SUM_VALID,
    input  logic                SUM_READY,
    output logic [ACC_BITS-1:0] SUM,
    output logic [NBITS-1:0]    XMAX
`ifdef XWIN_SAT_EN
    ,
    output logic                SUM_OVF
`endif
);

    localparam int unsigned         CNT_BITS = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WINDOW - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Running window state
    logic [ACC_BITS-1:0] acc;
    logic [ACC_BITS-1:0] acc_next;
    logic [NBITS-1:0]    max_q;
    logic [NBITS-1:0]    max_next;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_next;

    // Presented window result
    logic [ACC_BITS-1:0] sum_q;
    logic [ACC_BITS-1:0] sum_next;
    logic [NBITS-1:0]    xmax_q;
    logic [NBITS-1:0]    xmax_next;

    // Datapath helpers
    logic [ACC_BITS-1:0] xin_ext;
    logic [ACC_BITS-1:0] acc_add;
    logic [NBITS-1:0]    max_upd;

`ifdef XWIN_SAT_EN
    logic                ovf_win;
    logic                ovf_win_next;
    logic                sum_ovf_q;
    logic                sum_ovf_next;
    logic [ACC_BITS:0]   add_full;
    logic                carry;
`endif

    assign xin_ext = ACC_BITS'(XIN);

`ifdef XWIN_SAT_EN
    // Add with one extra bit so that the carry-out selects saturation
    always_comb begin
        add_full = {1'b0, acc} + {1'b0, xin_ext};
        carry    = add_full[ACC_BITS];
        acc_add  = carry ? '1 : add_full[ACC_BITS-1:0];
    end
`else
    // Add with wrap-around modulo 2^ACC_BITS
    always_comb begin
        acc_add = acc + xin_ext;
    end
`endif

    // Running maximum, including the sample that is being offered now
    always_comb begin
        max_upd = (XIN > max_q) ? XIN : max_q;
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and datapath next values
    always_comb begin
        state_next = state;
        acc_next   = acc;
        max_next   = max_q;
        cnt_next   = cnt;
        sum_next   = sum_q;
        xmax_next  = xmax_q;
        XIN_READY  = 1'b0;
        SUM_VALID  = 1'b0;
`ifdef XWIN_SAT_EN
        ovf_win_next = ovf_win;
        sum_ovf_next = sum_ovf_q;
`endif
        case (state)
            ACCUM: begin
                XIN_READY = 1'b1;
                if (XIN_VALID) begin
                    acc_next = acc_add;
                    max_next = max_upd;
                    cnt_next = cnt + 1'b1;
`ifdef XWIN_SAT_EN
                    ovf_win_next = ovf_win | carry;
`endif
                    // The last sample of the window goes straight into the
                    // result registers, so SUM_VALID appears one cycle later.
                    if (cnt == CNT_LAST) begin
                        sum_next   = acc_add;
                        xmax_next  = max_upd;
                        state_next = HOLD;
`ifdef XWIN_SAT_EN
                        sum_ovf_next = ovf_win | carry;
`endif
                    end
                end
            end
            HOLD: begin
                SUM_VALID = 1'b1;
                if (SUM_READY) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                    max_next   = '0;
                    cnt_next   = '0;
`ifdef XWIN_SAT_EN
                    ovf_win_next = 1'b0;
                    sum_ovf_next = 1'b0;
`endif
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Datapath registers; reset discards any partial window and any pending result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc    <= '0;
            max_q  <= '0;
            cnt    <= '0;
            sum_q  <= '0;
            xmax_q <= '0;
        end else begin
            acc    <= acc_next;
            max_q  <= max_next;
            cnt    <= cnt_next;
            sum_q  <= sum_next;
            xmax_q <= xmax_next;
        end
    end

`ifdef XWIN_SAT_EN
    // Overflow flags: one sticky flag inside the window, one presented with SUM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_win   <= 1'b0;
            sum_ovf_q <= 1'b0;
        end else begin
            ovf_win   <= ovf_win_next;
            sum_ovf_q <= sum_ovf_next;
        end
    end

    assign SUM_OVF = sum_ovf_q;
`endif

    assign SUM  = sum_q;
    assign XMAX = xmax_q;

endmodule

// File: tb/tb_xout_window_accum.sv
// tb_xout_window_accum
//   Stimulus and scoreboard bench for xout_window_accum. The DUT is built with
//   ACC_BITS=8 so that windows overflow often. The bench also covers the
//   XWIN_SAT_EN build when that macro is defined.
`timescale 1ns/1ps

module tb_xout_window_accum;

    localparam int unsigned NB  = 8;
    localparam int unsigned WIN = 4;
    localparam int unsigned AB  = 8;
    localparam int unsigned LIM = (1 << AB) - 1;

    logic          CLK       = 1'b0;
    logic          RST       = 1'b1;
    logic          XIN_VALID = 1'b0;
    logic [NB-1:0] XIN       = '0;
    logic          SUM_READY = 1'b0;
    logic          XIN_READY;
    logic          SUM_VALID;
    logic [AB-1:0] SUM;
    logic [NB-1:0] XMAX;
`ifdef XWIN_SAT_EN
    logic          SUM_OVF;
`endif

    xout_window_accum #(
        .NBITS   (NB),
        .WINDOW  (WIN),
        .ACC_BITS(AB)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .XIN_VALID(XIN_VALID),
        .XIN      (XIN),
        .XIN_READY(XIN_READY),
        .SUM_VALID(SUM_VALID),
        .SUM_READY(SUM_READY),
        .SUM      (SUM),
        .XMAX     (XMAX)
`ifdef XWIN_SAT_EN
        ,
        .SUM_OVF  (SUM_OVF)
`endif
    );

    typedef struct {
        int unsigned sum;
        int unsigned mx;
        int unsigned ovf;
        int unsigned c;    // cycle of the last input handshake
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    bit          cur_active = 1'b0;
    int unsigned win_q[$];
    int unsigned cyc        = 0;
    int          checks     = 0;
    int          errors     = 0;
    int unsigned stall      = 0;
    bit          rand_ready = 1'b0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference result for one complete window, from the sample list alone
    function automatic exp_t model(input int unsigned c);
        exp_t        e;
        longint unsigned total;
        int unsigned mx;
        total = 0;
        mx    = 0;
        foreach (win_q[i]) begin
            total += win_q[i];
            if (win_q[i] > mx) mx = win_q[i];
        end
`ifdef XWIN_SAT_EN
        e.sum = (total > LIM) ? LIM : int'(total);
        e.ovf = (total > LIM) ? 1 : 0;
`else
        e.sum = int'(total % (LIM + 1));
        e.ovf = 0;
`endif
        e.mx = mx;
        e.c  = c;
        return e;
    endfunction

    // Offer one sample and wait for its handshake (bounded); then wait for an optional idle gap
    task automatic send(input int unsigned v, input int unsigned gap);
        bit          r;
        int unsigned n;
        n         = 0;
        r         = 1'b0;
        XIN_VALID = 1'b1;
        XIN       = NB'(v);
        do begin
            @(negedge CLK);
            r = XIN_READY;
            @(posedge CLK);
            n++;
        end while (!r && n < 200);
        #1;
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d required=1 (sample %0d)", r, v);
            XIN_VALID = 1'b0;
        end else begin
            win_q.push_back(v);
            if (win_q.size() == WIN) begin
                sb.push_back(model(cyc));
                win_q.delete();
            end
            if (gap > 0) begin
                XIN_VALID = 1'b0;
                XIN       = NB'($urandom);
                repeat (gap) begin
                    @(posedge CLK);
                    #1;
                end
            end
        end
    endtask

    task automatic idle();
        XIN_VALID = 1'b0;
        XIN       = NB'($urandom);
    endtask

    // Reset for one cycle; check outputs while reset is held
    task automatic do_reset();
        RST        = 1'b1;
        XIN_VALID  = 1'b0;
        win_q.delete();
        sb.delete();
        cur_active = 1'b0;
        @(negedge CLK);
        check("rst_sum", SUM, 0);
        check("rst_xmax", XMAX, 0);
        check("rst_sum_valid", SUM_VALID, 0);
`ifdef XWIN_SAT_EN
        check("rst_sum_ovf", SUM_OVF, 0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // SUM_READY driver: random in ACCUM (must be ignored); stalled or random in HOLD
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (SUM_VALID && stall > 0) begin
                SUM_READY = 1'b0;
                stall--;
            end else if (SUM_VALID) begin
                SUM_READY = rand_ready ? 1'($urandom % 2) : 1'b1;
            end else begin
                SUM_READY = 1'($urandom % 2);
            end
        end
    end

    // Monitor: compare the DUT with the scoreboard at every falling edge
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (!cur_active && sb.size() > 0 && sb[0].c <= cyc) begin
                    cur        = sb.pop_front();
                    cur_active = 1'b1;
                end
                check("sum_valid", SUM_VALID, cur_active);
                check("xin_ready", XIN_READY, !cur_active);
                if (cur_active) begin
                    check("sum", SUM, cur.sum);
                    check("xmax", XMAX, cur.mx);
`ifdef XWIN_SAT_EN
                    check("sum_ovf", SUM_OVF, cur.ovf);
`endif
                    if (SUM_READY) cur_active = 1'b0;
                end
            end
        end
    end

    initial begin
        int unsigned r;
        int unsigned v;
        int unsigned n;

        do_reset();

        // Four back-to-back samples with the result accepted at once
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        idle();
        repeat (3) begin @(posedge CLK); #1; end

        // The result is held for 5 cycles; the sample 9 waits until the next window
        stall = 5;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        send(9, 0); send(1, 0); send(1, 0); send(1, 0);
        idle();
        repeat (3) begin @(posedge CLK); #1; end

        // Gaps between samples
        send(7, 2); send(0, 2); send(200, 2); send(3, 2);
        idle();
        repeat (3) begin @(posedge CLK); #1; end

        // Overflow window followed by a small window
        send(255, 0); send(255, 0); send(255, 0); send(255, 0);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        idle();
        repeat (3) begin @(posedge CLK); #1; end

        // Reset in the middle of a window
        send(100, 0); send(100, 0);
        do_reset();
        send(5, 0); send(5, 0); send(5, 0); send(5, 0);
        idle();
        repeat (3) begin @(posedge CLK); #1; end

        // All-zero window
        send(0, 0); send(0, 0); send(0, 0); send(0, 0);
        idle();
        repeat (3) begin @(posedge CLK); #1; end

        // Reset while a result is pending
        stall = 3;
        send(50, 0); send(50, 0); send(50, 0); send(60, 0);
        idle();
        @(negedge CLK);
        @(posedge CLK);
        #1;
        do_reset();
        stall = 0;
        send(2, 0); send(3, 0); send(250, 0); send(1, 0);
        idle();
        repeat (3) begin @(posedge CLK); #1; end

        // Random samples, gaps and output back-pressure
        rand_ready = 1'b1;
        repeat (40 * WIN) begin
            r = $urandom % 8;
            if (r == 0)      v = 255;
            else if (r == 1) v = 0;
            else             v = $urandom % 256;
            send(v, $urandom % 3);
        end
        idle();
        rand_ready = 1'b0;

        // Drain the scoreboard (bounded)
        n = 0;
        while ((sb.size() > 0 || cur_active) && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain_pending", sb.size() + (cur_active ? 1 : 0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
